// File: rtl/branch_resolve.sv
// Execute-stage branch resolution unit. It works out the real outcome and
// target of each conditional branch, JAL and JALR, and compares them with the
// fetch-stage prediction. On a mismatch it redirects fetch and then ignores
// the wrong-path instructions that are still draining. Conditional branches
// also train the predictor, and the unit counts resolutions and mispredicts.
module branch_resolve #(
    parameter int SQUASH_CYCLES = 2,
    parameter int BP_INDEX_W    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mstall,
    input  logic                  ex_valid,
    input  logic [6:0]            ex_opcode,
    input  logic [2:0]            ex_funct3,
    input  logic [31:0]           ex_rs1_val,
    input  logic [31:0]           ex_rs2_val,
    input  logic [31:0]           ex_imm,
    input  logic [31:0]           ex_pc,
    input  logic [31:0]           ex_pc_p4,
    input  logic                  ex_pred_taken,
    input  logic [31:0]           ex_pred_target,
    output logic                  mispredict,
    output logic [31:0]           override_addr,
    output logic [BP_INDEX_W-1:0] bp_w_addr,
    output logic                  bp_did_branch,
    output logic                  bp_we,
    output logic [31:0]           branch_count,
    output logic [31:0]           mispredict_count
);

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic {
        IDLE,
        SQUASH
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [3:0]  squash_cnt;
    logic [3:0]  squash_cnt_next;

    logic        is_branch;
    logic        is_jal;
    logic        is_jalr;
    logic        is_ctrl;
    logic        cond_taken;
    logic        actual_taken;
    logic [31:0] target;
    logic        wrong;
    logic        accept;
    logic        take_ctrl;
    logic        take_branch;
    logic        issue_mispredict;

    // Decode the class, evaluate the condition and target, and compare with the prediction
    always_comb begin
        is_branch  = 1'b0;
        is_jal     = 1'b0;
        is_jalr    = 1'b0;
        cond_taken = 1'b0;
        target     = ex_pc + ex_imm;

        if (ex_opcode == OP_BRANCH) begin
            is_branch = (ex_funct3 != 3'b010) && (ex_funct3 != 3'b011);
        end
        is_jal  = (ex_opcode == OP_JAL);
        is_jalr = (ex_opcode == OP_JALR);

        case (ex_funct3)
            3'b000:  cond_taken = (ex_rs1_val == ex_rs2_val);
            3'b001:  cond_taken = (ex_rs1_val != ex_rs2_val);
            3'b100:  cond_taken = ($signed(ex_rs1_val) <  $signed(ex_rs2_val));
            3'b101:  cond_taken = ($signed(ex_rs1_val) >= $signed(ex_rs2_val));
            3'b110:  cond_taken = (ex_rs1_val <  ex_rs2_val);
            3'b111:  cond_taken = (ex_rs1_val >= ex_rs2_val);
            default: cond_taken = 1'b0;
        endcase

        if (is_jalr) begin
            target = (ex_rs1_val + ex_imm) & 32'hFFFF_FFFE;
        end

        is_ctrl      = is_branch | is_jal | is_jalr;
        actual_taken = is_jal | is_jalr | (is_branch & cond_taken);
        wrong        = (actual_taken != ex_pred_taken) ||
                       (actual_taken && ex_pred_taken && (target != ex_pred_target));

        accept           = ex_valid && !mstall && (state == IDLE);
        take_ctrl        = accept && is_ctrl;
        take_branch      = accept && is_branch;
        issue_mispredict = take_ctrl && wrong;
    end

    // Next-state logic for the wrong-path squash window
    always_comb begin
        state_next      = state;
        squash_cnt_next = squash_cnt;
        case (state)
            IDLE: begin
                if (issue_mispredict) begin
                    state_next      = SQUASH;
                    squash_cnt_next = 4'(SQUASH_CYCLES);
                end
            end
            SQUASH: begin
                if (!mstall) begin
                    if (squash_cnt <= 4'd1) begin
                        state_next      = IDLE;
                        squash_cnt_next = 4'd0;
                    end else begin
                        squash_cnt_next = squash_cnt - 4'd1;
                    end
                end
            end
            default: begin
                state_next      = IDLE;
                squash_cnt_next = 4'd0;
            end
        endcase
    end

    // State register and squash counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            squash_cnt <= 4'd0;
        end else begin
            state      <= state_next;
            squash_cnt <= squash_cnt_next;
        end
    end

    // Registered redirect, predictor writeback and counters
    always_ff @(posedge clk) begin
        if (rst) begin
            mispredict       <= 1'b0;
            override_addr    <= 32'd0;
            bp_w_addr        <= '0;
            bp_did_branch    <= 1'b0;
            bp_we            <= 1'b0;
            branch_count     <= 32'd0;
            mispredict_count <= 32'd0;
        end else begin
            mispredict <= issue_mispredict;
            bp_we      <= take_branch;
            if (issue_mispredict) begin
                override_addr    <= actual_taken ? target : ex_pc_p4;
                mispredict_count <= mispredict_count + 32'd1;
            end
            if (take_branch) begin
                bp_w_addr     <= ex_pc[BP_INDEX_W+1:2];
                bp_did_branch <= actual_taken;
            end
            if (take_ctrl) begin
                branch_count <= branch_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve.sv
// Testbench for branch_resolve: directed scenarios plus randomized traffic,
// all checked cycle by cycle against a behavioural model of the unit.
module tb_branch_resolve;

    localparam int SQ = 2;

    logic        clk;
    logic        rst;
    logic        mstall;
    logic        ex_valid;
    logic [6:0]  ex_opcode;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_rs1_val;
    logic [31:0] ex_rs2_val;
    logic [31:0] ex_imm;
    logic [31:0] ex_pc;
    logic [31:0] ex_pc_p4;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        mispredict;
    logic [31:0] override_addr;
    logic [7:0]  bp_w_addr;
    logic        bp_did_branch;
    logic        bp_we;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    int checks = 0;
    int errors = 0;

    // Model state: cycles left to ignore plus the expected output values
    int          mIgnore = 0;
    logic        mMis = 0;
    logic        mWe = 0;
    logic [31:0] mOvr = 0;
    logic [7:0]  mAddr = 0;
    logic        mDid = 0;
    logic [31:0] mBc = 0;
    logic [31:0] mMc = 0;

    branch_resolve #(.SQUASH_CYCLES(SQ), .BP_INDEX_W(8)) dut (
        .clk(clk), .rst(rst), .mstall(mstall), .ex_valid(ex_valid),
        .ex_opcode(ex_opcode), .ex_funct3(ex_funct3),
        .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val), .ex_imm(ex_imm),
        .ex_pc(ex_pc), .ex_pc_p4(ex_pc_p4), .ex_pred_taken(ex_pred_taken),
        .ex_pred_target(ex_pred_target), .mispredict(mispredict),
        .override_addr(override_addr), .bp_w_addr(bp_w_addr),
        .bp_did_branch(bp_did_branch), .bp_we(bp_we),
        .branch_count(branch_count), .mispredict_count(mispredict_count)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // Count one comparison and report it if observed differs from expected
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=0x%08h expected=0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Architectural meaning of a control-transfer instruction
    task automatic resolve(input logic [6:0] op, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] imm, input logic [31:0] pc,
                           output bit ctrl, output bit br, output bit taken,
                           output logic [31:0] tgt);
        int sa;
        int sb;
        sa = a;
        sb = b;
        ctrl = 0; br = 0; taken = 0; tgt = pc + imm;
        if (op == 7'b1101111) begin
            ctrl = 1; taken = 1;
        end else if (op == 7'b1100111) begin
            ctrl = 1; taken = 1;
            tgt = a + imm;
            tgt[0] = 1'b0;
        end else if (op == 7'b1100011 && f3 != 3'd2 && f3 != 3'd3) begin
            ctrl = 1; br = 1;
            case (f3)
                3'd0: taken = (a == b);
                3'd1: taken = (a != b);
                3'd4: taken = (sa < sb);
                3'd5: taken = (sa >= sb);
                3'd6: taken = (a < b);
                default: taken = (a >= b);
            endcase
        end
    endtask

    // Drive one cycle, advance the model at the edge, and compare every output
    task automatic applyStimulus(input logic r, input logic v, input logic s,
                                 input logic [6:0] op, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] imm, input logic [31:0] pc,
                                 input logic pt, input logic [31:0] ptgt);
        bit ctrl;
        bit br;
        bit taken;
        logic [31:0] tgt;
        rst = r; ex_valid = v; mstall = s; ex_opcode = op; ex_funct3 = f3;
        ex_rs1_val = a; ex_rs2_val = b; ex_imm = imm; ex_pc = pc;
        ex_pc_p4 = pc + 32'd4; ex_pred_taken = pt; ex_pred_target = ptgt;
        @(posedge clk);
        mMis = 0;
        mWe = 0;
        if (r) begin
            mIgnore = 0; mOvr = 0; mAddr = 0; mDid = 0; mBc = 0; mMc = 0;
        end else if (mIgnore > 0) begin
            if (!s) mIgnore--;
        end else if (v && !s) begin
            resolve(op, f3, a, b, imm, pc, ctrl, br, taken, tgt);
            if (ctrl) begin
                mBc++;
                if (taken != pt || (taken && tgt != ptgt)) begin
                    mMis = 1;
                    mMc++;
                    mOvr = taken ? tgt : pc + 32'd4;
                    mIgnore = SQ;
                end
                if (br) begin
                    mWe = 1;
                    mAddr = pc[9:2];
                    mDid = taken;
                end
            end
        end
        #1;
        checkOutput("mispredict", 32'(mispredict), 32'(mMis));
        checkOutput("bp_we", 32'(bp_we), 32'(mWe));
        checkOutput("override_addr", override_addr, mOvr);
        checkOutput("bp_w_addr", 32'(bp_w_addr), 32'(mAddr));
        checkOutput("bp_did_branch", 32'(bp_did_branch), 32'(mDid));
        checkOutput("branch_count", branch_count, mBc);
        checkOutput("mispredict_count", mispredict_count, mMc);
    endtask

    task automatic resetCycle();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic beqMiss(input logic s);
        applyStimulus(0, 1, s, 7'b1100011, 3'd0, 5, 5, 32'h40, 32'h100, 0, 0);
    endtask

    initial begin
        logic [6:0]  ops[6];
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [31:0] pc;
        bit          ctrl;
        bit          br;
        bit          taken;
        logic [31:0] tgt;

        ops[0] = 7'b1100011; ops[1] = 7'b1100011; ops[2] = 7'b1101111;
        ops[3] = 7'b1100111; ops[4] = 7'b0110011; ops[5] = 7'b0010011;

        // Reset state
        resetCycle();
        checkOutput("reset_bc", branch_count, 0);
        checkOutput("reset_mis", 32'(mispredict), 0);

        // BEQ predicted not-taken but taken
        beqMiss(0);
        checkOutput("beq_mis", 32'(mispredict), 1);
        checkOutput("beq_ovr", override_addr, 32'h140);
        checkOutput("beq_addr", 32'(bp_w_addr), 32'h40);
        checkOutput("beq_mc", mispredict_count, 1);

        // BNE correctly predicted taken
        resetCycle();
        applyStimulus(0, 1, 0, 7'b1100011, 3'd1, 1, 2, 32'h40, 32'h100, 1, 32'h140);
        checkOutput("bne_mis", 32'(mispredict), 0);
        checkOutput("bne_did", 32'(bp_did_branch), 1);
        checkOutput("bne_bc", branch_count, 1);

        // BLT signed taken, BLTU same operands not taken
        applyStimulus(0, 1, 0, 7'b1100011, 3'd4, 32'hFFFF_FFFF, 1, 32'h20, 32'h200, 1, 32'h220);
        checkOutput("blt_mis", 32'(mispredict), 0);
        applyStimulus(0, 1, 0, 7'b1100011, 3'd6, 32'hFFFF_FFFF, 1, 32'h20, 32'h200, 1, 32'h220);
        checkOutput("bltu_ovr", override_addr, 32'h204);
        checkOutput("bltu_did", 32'(bp_did_branch), 0);

        // JALR clears bit 0 of the target and never trains the predictor
        resetCycle();
        applyStimulus(0, 1, 0, 7'b1100111, 3'd0, 32'h2001, 0, 32'h10, 32'h300, 0, 0);
        checkOutput("jalr_ovr", override_addr, 32'h2010);
        checkOutput("jalr_we", 32'(bp_we), 0);

        // Two wrong-path cycles ignored, third resolved
        resetCycle();
        beqMiss(0); beqMiss(0); beqMiss(0); beqMiss(0);
        checkOutput("squash_mc", mispredict_count, 2);

        // mstall mid-squash stretches the window
        resetCycle();
        beqMiss(0); beqMiss(0);
        beqMiss(1); beqMiss(1); beqMiss(1);
        beqMiss(0);
        checkOutput("stall_mc_hold", mispredict_count, 1);
        beqMiss(0);
        checkOutput("stall_mc", mispredict_count, 2);

        // Reset in the middle of a squash window
        resetCycle();
        beqMiss(0);
        resetCycle();
        checkOutput("rst_sq_mc", mispredict_count, 0);
        beqMiss(0);
        checkOutput("rst_sq_mis", 32'(mispredict), 1);

        // Randomized traffic against the model
        resetCycle();
        for (int i = 0; i < 600; i++) begin
            op  = ops[$urandom_range(0, 5)];
            f3  = 3'($urandom);
            a   = $urandom;
            b   = ($urandom_range(0, 2) == 0) ? a : $urandom;
            imm = 32'($signed(13'($urandom)));
            pc  = {$urandom_range(0, 32'h3FFF), 2'b00};
            resolve(op, f3, a, b, imm, pc, ctrl, br, taken, tgt);
            applyStimulus($urandom_range(0, 49) == 0, $urandom_range(0, 4) != 0,
                          $urandom_range(0, 4) == 0, op, f3, a, b, imm, pc,
                          1'($urandom),
                          ($urandom_range(0, 3) != 0) ? tgt : $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
